// File: rtl/n_bit_adder.sv
// Unsigned ripple-carry adder: {Cout,Sum} = A + B + Cin, built from per-bit full-adder cells.
// Latency: one cycle. Operands sampled at rising clk, result held until the next edge.
// Backpressure: none. The block accepts a new operand set every cycle and has no stall path.

// Single-bit full adder, the unit cell of the carry chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic half_sum;

    // Propagate term is shared between the sum and the carry-out.
    assign half_sum = a ^ b;
    assign s        = half_sum ^ ci;
    assign co       = (a & b) | (ci & half_sum);

endmodule

module n_bit_adder #(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] A,
    input  logic [Width-1:0] B,
    input  logic             Cin,
    output logic [Width-1:0] Sum,
    output logic             Cout
);

    // carry[i] is the carry into bit i; carry[Width] is the final carry-out.
    logic [Width:0]   carry;
    logic [Width-1:0] sum_next;

    assign carry[0] = Cin;

    // One full-adder cell per bit, chained through the carry vector.
    for (genvar i = 0; i < Width; i++) begin : g_chain
        full_adder_cell u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (sum_next[i]),
            .co (carry[i+1])
        );
    end

    // Capture the chain result every cycle; reset clears outputs immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum  <= '0;
            Cout <= 1'b0;
        end else begin
            Sum  <= sum_next;
            Cout <= carry[Width];
        end
    end

endmodule

// File: tb/tb_n_bit_adder.sv
// Bench for n_bit_adder: directed vectors, random vectors and reset scenarios.
// Expected results are computed arithmetically and queued at each capture edge.
// A monitor on the falling edge pops and compares against the registered outputs.
module tb_n_bit_adder;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cin   = 1'b0;
    logic [W-1:0] sum;
    logic         cout;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W:0]   exp;
    } txn_t;

    txn_t sb[$];
    int   checks = 0;
    int   errors = 0;

    n_bit_adder #(.Width(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .Sum   (sum),
        .Cout  (cout)
    );

    always #5 clk = ~clk;

    // Reference: plain integer addition, carry-out is whatever exceeds W bits.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int unsigned total;
        total = int'(x) + int'(y) + int'(c);
        return total[W:0];
    endfunction

    task automatic check(input string name, input logic [W:0] got, input logic [W:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got cout=%0b sum=%02h, expected cout=%0b sum=%02h",
                     name, got[W], got[W-1:0], req[W], req[W-1:0]);
        end
    endtask

    // Every capture edge outside reset produces one expected result.
    always @(posedge clk) begin
        txn_t t;
        if (rst_n) begin
            t.a   = a;
            t.b   = b;
            t.cin = cin;
            t.exp = ref_add(a, b, cin);
            sb.push_back(t);
        end
    end

    // Monitor: outputs must be zero in reset, otherwise match the oldest queued result.
    always @(negedge clk) begin
        txn_t t;
        if (!rst_n) begin
            check("reset_hold", {cout, sum}, '0);
        end else if (sb.size() > 0) begin
            t = sb.pop_front();
            check($sformatf("add %02h+%02h+%0b", t.a, t.b, t.cin), {cout, sum}, t.exp);
        end
    end

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        @(posedge clk);
        #1;
        a   = x;
        b   = y;
        cin = c;
    endtask

    initial begin
        // Reset held with nonzero operands; outputs must stay zero.
        a = 8'h55; b = 8'hAA; cin = 1'b1;
        #1;
        check("reset_init", {cout, sum}, '0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_after_edges", {cout, sum}, '0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Directed: basic add, carry-in, ripple/wrap, per-cycle latency.
        drive(8'h12, 8'h34, 1'b0);
        drive(8'h12, 8'h34, 1'b1);
        drive(8'hFF, 8'h01, 1'b0);
        drive(8'hFF, 8'hFF, 1'b1);
        drive(8'd3,   8'd4,   1'b0);
        drive(8'd10,  8'd20,  1'b0);
        drive(8'd200, 8'd100, 1'b0);
        drive(8'h00, 8'h00, 1'b0);
        drive(8'h00, 8'h00, 1'b1);
        drive(8'hFF, 8'h00, 1'b1);
        drive(8'h80, 8'h80, 1'b0);
        drive(8'h7F, 8'h80, 1'b1);

        // Random operands, one per cycle.
        for (int i = 0; i < 2000; i++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom));
        end

        // Async reset between edges while operands are nonzero.
        drive(8'h5A, 8'h33, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_reset_midcycle", {cout, sum}, '0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        drive(8'hC3, 8'h3C, 1'b0);
        drive(8'h01, 8'hFE, 1'b1);

        for (int i = 0; i < 200; i++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        #1;
        // The monitor pops once per cycle, so at most one result may be pending.
        checks++;
        if (sb.size() > 1) begin
            errors++;
            $display("FAIL scoreboard_backlog: pending=%0d, expected at most 1", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
